// File: rtl/risc_v_mike_pkg.sv
// Shared types for the risc_v_mike core: PC/data widths, fetch FSM states and
// the fetch queue entry, plus the fetch-address legality rule.
package risc_v_mike_pkg;

  localparam int DATA_32_W = 32;

  typedef logic [31:0] t_pc_addr;

  localparam t_pc_addr PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } t_fetch_state;

  typedef struct packed {
    t_pc_addr               pc;
    logic [DATA_32_W-1:0]   instr;
  } t_fetch_entry;

  // Word-aligned and inside the instruction memory.
  function automatic logic pc_is_legal(input t_pc_addr pc, input int unsigned depth);
    return (pc[1:0] == 2'b00) && (pc < t_pc_addr'(depth * 32'd4));
  endfunction

endpackage

// File: rtl/risc_v_mike_fetch_unit_if.sv
// Fetch unit bus: instruction memory port, redirect input, decode handshake
// and fault reporting. master = fetch unit, slave = its environment.
interface risc_v_mike_fetch_unit_if;
  import risc_v_mike_pkg::*;

  logic                 fetch_en;
  t_pc_addr             imem_addr;
  logic [DATA_32_W-1:0] imem_rd_data;
  logic                 redirect_valid;
  t_pc_addr             redirect_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_32_W-1:0] out_instr;
  t_pc_addr             out_pc;
  logic                 fault;
  t_pc_addr             fault_pc;

  modport master (
    input  fetch_en, imem_rd_data, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc
  );

  modport slave (
    output fetch_en, imem_rd_data, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc
  );

endinterface

// File: rtl/risc_v_mike_fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr}. Vacated slots are zeroed, so the head
// register reads as zero whenever the queue is empty.
module risc_v_mike_fetch_queue
  import risc_v_mike_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  t_fetch_entry i_data,
  output t_fetch_entry o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  t_fetch_entry r_entry0;
  t_fetch_entry r_entry1;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_count  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_entry0 <= i_data;
          else                 r_entry1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_entry0 <= r_entry1;
          r_entry1 <= '0;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_entry0 <= i_data;
          end else begin
            r_entry0 <= r_entry1;
            r_entry1 <= i_data;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign o_head  = r_entry0;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch controller: owns the PC, reads the combinational
// instruction memory and buffers {pc, instr} for decode in a 2-entry queue.
module risc_v_mike_fetch_unit
  import risc_v_mike_pkg::*;
#(
  parameter t_pc_addr    RESET_PC   = 32'h0000_0008,
  parameter int unsigned IMEM_DEPTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  risc_v_mike_fetch_unit_if.master bus
);

  t_fetch_state r_state;
  t_pc_addr     r_pc;
  logic         r_fault;
  t_pc_addr     r_fault_pc;

  t_fetch_entry w_head;
  t_fetch_entry w_new;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;
  logic         w_pop;
  logic         w_push;
  logic         w_pc_legal;
  logic         w_redirect_legal;
  logic         w_unused;

  assign w_pc_legal       = pc_is_legal(r_pc, IMEM_DEPTH);
  assign w_redirect_legal = pc_is_legal(bus.redirect_pc, IMEM_DEPTH);
  assign w_pop            = !w_empty && bus.out_ready;
  // A full queue still accepts a push when decode drains the head this cycle.
  assign w_push           = (r_state == FETCH_RUN) && bus.fetch_en && !bus.redirect_valid &&
                            w_pc_legal && (!w_full || w_pop);
  assign w_new            = '{pc: r_pc, instr: bus.imem_rd_data};
  assign w_unused         = &{1'b0, w_count};

  risc_v_mike_fetch_queue u_queue (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  (w_new),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH_IDLE;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_pc <= bus.redirect_pc;
      if (w_redirect_legal) begin
        r_state <= bus.fetch_en ? FETCH_RUN : FETCH_IDLE;
        r_fault <= 1'b0;
      end else begin
        r_state    <= FETCH_FAULT;
        r_fault    <= 1'b1;
        r_fault_pc <= bus.redirect_pc;
      end
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (bus.fetch_en) r_state <= FETCH_RUN;
          else              r_state <= FETCH_IDLE;
        end
        FETCH_RUN: begin
          if (!bus.fetch_en) begin
            r_state <= FETCH_IDLE;
          end else if (!w_pc_legal) begin
            r_state    <= FETCH_FAULT;
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
          end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
          end else begin
            r_pc <= r_pc;
          end
        end
        FETCH_FAULT: begin
          r_state <= FETCH_FAULT;
        end
        default: begin
          r_state <= FETCH_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_instr = w_head.instr;
  assign bus.out_pc    = w_head.pc;
  assign bus.fault     = r_fault;
  assign bus.fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
// Scoreboard bench for risc_v_mike_fetch_unit: stimulus queues the expected
// instruction stream per reset/redirect epoch, a negedge monitor checks handshakes.
module tb_risc_v_mike_fetch_unit;
  import risc_v_mike_pkg::*;

  localparam t_pc_addr RST_PC = 32'h0000_0008;
  localparam int       DEPTH  = 96;
  localparam int       LIMIT  = DEPTH * 4;

  typedef struct {
    int          epoch;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  risc_v_mike_fetch_unit_if bus_if ();

  risc_v_mike_fetch_unit #(.RESET_PC(RST_PC), .IMEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];

  always_comb begin
    if (int'(bus_if.imem_addr) < LIMIT && bus_if.imem_addr < 32'h0000_1000)
      bus_if.imem_rd_data = mem[int'(bus_if.imem_addr) / 4];
    else
      bus_if.imem_rd_data = 32'hDEAD_BEEF;
  end

  exp_t        exp_q[$];
  int          stim_epoch = 0;
  int          dut_epoch  = 0;
  int          vectors    = 0;
  int          errors     = 0;
  logic [31:0] last_pc    = 32'h0;

  function automatic bit legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc < 32'(LIMIT));
  endfunction

  // New epoch: the DUT must now deliver every legal word from start upward, in order.
  task automatic load_stream(input logic [31:0] start);
    stim_epoch++;
    if (legal(start))
      for (int p = int'(start); p < LIMIT; p += 4)
        exp_q.push_back('{stim_epoch, 32'(p), mem[p / 4]});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && bus_if.out_valid && bus_if.out_ready) begin
        while (exp_q.size() > 0 && exp_q[0].epoch < dut_epoch) exp_q.delete(0);
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL extra_output: got pc %h, expected no entry at %0t", bus_if.out_pc, $time);
        end else begin
          check("handshake_pc", bus_if.out_pc, exp_q[0].pc);
          check("handshake_instr", bus_if.out_instr, exp_q[0].instr);
          exp_q.delete(0);
        end
        last_pc = bus_if.out_pc;
      end
      if (!bus_if.out_valid) begin
        check("empty_pc_zero", bus_if.out_pc, 32'h0);
        check("empty_instr_zero", bus_if.out_instr, 32'h0);
      end
      if (rst || bus_if.redirect_valid) dut_epoch = stim_epoch;
    end
  end

  initial begin : stimulus
    logic [31:0] tgt;
    int          r;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[2]  = 32'h0010_0093;
    mem[10] = 32'h0080_2423;

    bus_if.fetch_en       = 1'b0;
    bus_if.out_ready      = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    rst                   = 1'b1;
    load_stream(RST_PC);
    step();
    step();
    check("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
    check("rst_out_pc", bus_if.out_pc, 32'h0);
    check("rst_out_instr", bus_if.out_instr, 32'h0);
    check("rst_fault", 32'(bus_if.fault), 32'h0);
    check("rst_fault_pc", bus_if.fault_pc, 32'h0);
    check("rst_imem_addr", bus_if.imem_addr, 32'h8);

    // Streaming from reset, one instruction per cycle.
    rst             = 1'b0;
    bus_if.fetch_en = 1'b1;
    step();
    check("first_cycle_empty", 32'(bus_if.out_valid), 32'h0);
    step();
    check("first_valid", 32'(bus_if.out_valid), 32'h1);
    check("first_pc", bus_if.out_pc, 32'h8);
    check("first_instr", bus_if.out_instr, 32'h0010_0093);
    step();
    check("stream_pc_c", bus_if.out_pc, 32'hC);
    step();
    check("stream_pc_10", bus_if.out_pc, 32'h10);

    // Backpressure: two entries held, PC frozen at 0x10.
    rst              = 1'b1;
    bus_if.out_ready = 1'b0;
    load_stream(RST_PC);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("stall_valid", 32'(bus_if.out_valid), 32'h1);
    check("stall_head_pc", bus_if.out_pc, 32'h8);
    check("stall_imem_addr", bus_if.imem_addr, 32'h10);
    bus_if.out_ready = 1'b1;
    step();
    check("drain_pc_c", bus_if.out_pc, 32'hC);
    step();
    check("drain_pc_10", bus_if.out_pc, 32'h10);

    // Redirect while full with a concurrent pop.
    bus_if.out_ready = 1'b0;
    step();
    step();
    bus_if.out_ready      = 1'b1;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h28;
    load_stream(32'h28);
    step();
    bus_if.redirect_valid = 1'b0;
    check("redirect_flush_valid", 32'(bus_if.out_valid), 32'h0);
    step();
    check("redirect_target_pc", bus_if.out_pc, 32'h28);
    check("redirect_target_instr", bus_if.out_instr, 32'h0080_2423);

    // Misaligned redirect faults, a legal redirect recovers.
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h2A;
    load_stream(32'h2A);
    step();
    bus_if.redirect_valid = 1'b0;
    check("misalign_fault", 32'(bus_if.fault), 32'h1);
    check("misalign_fault_pc", bus_if.fault_pc, 32'h2A);
    step();
    step();
    check("fault_no_push", 32'(bus_if.out_valid), 32'h0);
    check("fault_held", 32'(bus_if.fault), 32'h1);
    check("fault_imem_addr", bus_if.imem_addr, 32'h2A);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h8;
    load_stream(32'h8);
    step();
    bus_if.redirect_valid = 1'b0;
    check("recover_fault_clear", 32'(bus_if.fault), 32'h0);
    step();
    check("recover_pc", bus_if.out_pc, 32'h8);

    // Run off the end of the instruction memory.
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h170;
    load_stream(32'h170);
    step();
    bus_if.redirect_valid = 1'b0;
    repeat (8) step();
    check("end_fault", 32'(bus_if.fault), 32'h1);
    check("end_fault_pc", bus_if.fault_pc, 32'h180);
    check("end_valid", 32'(bus_if.out_valid), 32'h0);
    check("end_last_pc", last_pc, 32'h17C);

    // Reset wins over a simultaneous redirect.
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h40;
    load_stream(32'h40);
    step();
    bus_if.redirect_valid = 1'b0;
    repeat (3) step();
    rst                   = 1'b1;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h50;
    load_stream(RST_PC);
    step();
    rst                   = 1'b0;
    bus_if.redirect_valid = 1'b0;
    check("midrst_valid", 32'(bus_if.out_valid), 32'h0);
    check("midrst_pc", bus_if.out_pc, 32'h0);
    check("midrst_instr", bus_if.out_instr, 32'h0);
    check("midrst_fault", 32'(bus_if.fault), 32'h0);
    check("midrst_fault_pc", bus_if.fault_pc, 32'h0);
    check("midrst_imem_addr", bus_if.imem_addr, 32'h8);

    // Randomized traffic: enables, backpressure, redirects (some illegal), resets.
    for (int c = 0; c < 3000; c++) begin
      bus_if.fetch_en       = ($urandom_range(0, 9) != 0);
      bus_if.out_ready      = ($urandom_range(0, 9) < 7);
      bus_if.redirect_valid = 1'b0;
      rst                   = 1'b0;
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        rst = 1'b1;
        load_stream(RST_PC);
      end else if (r < 9) begin
        case ($urandom_range(0, 5))
          0:       tgt = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
          1:       tgt = 32'(LIMIT + $urandom_range(0, 63) * 4);
          default: tgt = 32'($urandom_range(0, DEPTH - 1) * 4);
        endcase
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = tgt;
        load_stream(tgt);
      end
      step();
    end
    rst                   = 1'b0;
    bus_if.redirect_valid = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/risc_v_mike_fetch_unit.md
# risc_v_mike_fetch_unit

Instruction fetch controller for the risc_v_mike core. It sequences the instruction memory: it owns the program counter, drives the memory word address, and buffers fetched words with their PCs in a 2-entry queue. Decode consumes entries through a valid/ready handshake. Branch/jump redirects flush the queue and reload the PC. The block sits between risc_v_mike_instruction_memory (combinational read) and the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0008, first fetch address after reset (byte address of word 2).
- IMEM_DEPTH, 96, number of valid 32-bit words; a fetch at or above IMEM_DEPTH*4 is a fault.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- fetch_en  in  1  permit fetching
- imem_addr  out  t_pc_addr (32)  byte address to instruction memory
- imem_rd_data  in  DATA_32_W  instruction word, valid in the same cycle as imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  t_pc_addr  redirect target byte address
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  DATA_32_W  head instruction
- out_pc  out  t_pc_addr  head PC
- fault  out  1  fetch fault latched
- fault_pc  out  t_pc_addr  offending address

## Operation
- Reset values: pc_q=RESET_PC, state=IDLE, queue empty, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
- imem_addr = pc_q at all times.
- FSM states:
  - IDLE: no pushes; moves to RUN when fetch_en=1.
  - RUN: pushes when fetch_en=1; returns to IDLE when fetch_en=0. The queue is retained in IDLE and decode may drain it.
  - FAULT: no pushes; fault=1; leaves only on redirect_valid with a legal target (to RUN if fetch_en, else IDLE).
- Push condition (RUN, no redirect, pc_q legal, queue not full or pop this cycle): enqueue {pc_q, imem_rd_data}, then pc_q += 4. The addition is 32-bit and wraps.
- pc_q is legal when pc_q[1:0]==0 and pc_q < IMEM_DEPTH*4.
- Illegal pc_q in RUN: enter FAULT and set fault_pc=pc_q. The queue is kept, so entries already fetched remain consumable.
- Pop: when out_valid && out_ready, the head is removed.
- Queue: 2 entries, occupancy 0..2. Push and pop in the same cycle is allowed at any occupancy, including full.
- Redirect has priority over everything except rst:
  - The queue is flushed and pc_q<=redirect_pc.
  - No push occurs that cycle.
  - A pop handshake in the same cycle still counts as consumed by decode.
  - An illegal redirect_pc enters FAULT next cycle with fault_pc=redirect_pc.
- fault and fault_pc hold until a legal redirect or rst; a legal redirect clears fault.
- out_instr and out_pc show the head entry; they are 0 when the queue is empty.

## Timing
- Fetch-to-out_valid latency: 1 cycle. A word is pushed at edge N and out_valid=1 after edge N.
- Redirect at edge N: out_valid=0 after N. The first target instruction is pushed at edge N+1 and visible after N+1.
- Sustained throughput: 1 instruction/cycle with out_ready=1.
- With out_ready=0: two pushes fill the queue, then pushes stop and pc_q holds.
- out_valid, out_instr and out_pc are driven from queue registers only; there is no combinational path from out_ready or redirect_valid.
- fetch_en low: pushing stops at the next edge. In-flight state is unaffected.
- rst mid-operation: all state returns to reset values at the next edge, regardless of redirect or handshake.

## Structure
- Shared package risc_v_mike_pkg holds:
  - t_pc_addr (32-bit) and DATA_32_W (existing);
  - t_fetch_state enum {FETCH_IDLE, FETCH_RUN, FETCH_FAULT};
  - t_fetch_entry struct {pc, instr};
  - PC_STEP=4.
- One sub-module: risc_v_mike_fetch_queue, a 2-entry FIFO of t_fetch_entry with push, pop, flush, full, empty and count.
- Flops use the team's synchronous-reset FF macro.

## Test plan
- Reset, fetch_en=1, out_ready=1 → out_pc sequence 0x8,0xC,0x10…, one per cycle from cycle 2; out_instr at 0x8 = 32'h00100093.
- out_ready=0 for 5 cycles → out_valid stays 1, two entries held, imem_addr frozen at 0x10. Then out_ready=1 → PCs 0x8,0xC,0x10 delivered in order with no gap or duplicate.
- Redirect to 0x28 while the queue holds 2 entries and a pop occurs → out_valid=0 next cycle, then out_pc=0x28, out_instr=32'h00802423. Flushed entries are never presented.
- Redirect to 0x2A → fault=1, fault_pc=0x2A, no pushes. A later redirect to 0x8 clears fault and resumes at 0x8.
- Sequential run to 0x180 (IMEM_DEPTH*4) → the last delivered PC is 0x17C, then fault=1, fault_pc=0x180.
- rst asserted mid-stream with a simultaneous redirect → next cycle all outputs are at reset values and imem_addr=0x8.
